// File: rtl/dirty_reg_encoder.sv
`default_nettype none
// ============================================================================
// Module   : dirty_reg_encoder
// Purpose  : Records per-register write enables into a dirty mask and drains
//            a snapshot of it as ascending binary indices over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module dirty_reg_encoder #(
    parameter int IGNORE_X0 = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] en,
    input  logic        start,
    input  logic        ready,
    output logic        valid,
    output logic [4:0]  A,
    output logic        busy,
    output logic        done,
    output logic [5:0]  dirty_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [31:0] C_X0_CLEAR = 32'hFFFF_FFFE;

    state_t      r_state_q, w_state_d;
    logic [31:0] r_mask_q,  w_mask_d;
    logic [31:0] r_snap_q,  w_snap_d;
    logic [4:0]  r_a_q,     w_a_d;
    logic        r_valid_q, w_valid_d;
    logic        r_done_q,  w_done_d;
    logic        r_busy_q,  w_busy_d;
    logic [5:0]  r_count_q, w_count_d;

    logic [31:0] w_en_m;
    logic [31:0] w_snap_left;

    function automatic logic [4:0] f_lowest(input logic [31:0] v);
        f_lowest = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) f_lowest = 5'(i);
        end
    endfunction

    function automatic logic [5:0] f_popcount(input logic [31:0] v);
        f_popcount = 6'd0;
        for (int i = 0; i < 32; i++) begin
            f_popcount = f_popcount + {5'd0, v[i]};
        end
    endfunction

    assign w_en_m      = (IGNORE_X0 != 0) ? (en & C_X0_CLEAR) : en;
    // Snapshot with the index currently being accepted removed.
    assign w_snap_left = r_snap_q & ~(32'h1 << r_a_q);

    always_comb begin
        w_state_d = r_state_q;
        w_mask_d  = r_mask_q | w_en_m;
        w_snap_d  = r_snap_q;
        w_a_d     = r_a_q;
        w_valid_d = r_valid_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    if (r_mask_q != 32'd0) begin
                        w_snap_d  = r_mask_q;
                        w_mask_d  = w_en_m;
                        w_a_d     = f_lowest(r_mask_q);
                        w_valid_d = 1'b1;
                        w_state_d = S_DRAIN;
                    end else begin
                        w_state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (r_valid_q && ready) begin
                    w_snap_d = w_snap_left;
                    if (w_snap_left != 32'd0) begin
                        w_a_d = f_lowest(w_snap_left);
                    end else begin
                        w_valid_d = 1'b0;
                        w_a_d     = 5'd0;
                        w_state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
                w_valid_d = 1'b0;
                w_a_d     = 5'd0;
            end
        endcase
        w_done_d  = (w_state_d == S_DONE);
        w_busy_d  = (w_state_d != S_IDLE);
        w_count_d = f_popcount(w_mask_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
            r_mask_q  <= 32'd0;
            r_snap_q  <= 32'd0;
            r_a_q     <= 5'd0;
            r_valid_q <= 1'b0;
            r_done_q  <= 1'b0;
            r_busy_q  <= 1'b0;
            r_count_q <= 6'd0;
        end else begin
            r_state_q <= w_state_d;
            r_mask_q  <= w_mask_d;
            r_snap_q  <= w_snap_d;
            r_a_q     <= w_a_d;
            r_valid_q <= w_valid_d;
            r_done_q  <= w_done_d;
            r_busy_q  <= w_busy_d;
            r_count_q <= w_count_d;
        end
    end

    assign valid       = r_valid_q;
    assign A           = r_a_q;
    assign busy        = r_busy_q;
    assign done        = r_done_q;
    assign dirty_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dirty_reg_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dirty_reg_encoder
// Purpose  : Scoreboard bench for dirty_reg_encoder against a set-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dirty_reg_encoder;

    localparam int C_IGNORE_X0 = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] en;
    logic        start;
    logic        ready;
    logic        valid;
    logic [4:0]  A;
    logic        busy;
    logic        done;
    logic [5:0]  dirty_count;

    always #5 clk = ~clk;

    dirty_reg_encoder #(.IGNORE_X0(C_IGNORE_X0)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .start       (start),
        .ready       (ready),
        .valid       (valid),
        .A           (A),
        .busy        (busy),
        .done        (done),
        .dirty_count (dirty_count)
    );

    int total = 0;
    int bad   = 0;

    // Model: dirty set, list of indices still owed in this drain, and phase
    // (0 = idle, 1 = draining, 2 = done-cycle). -1 in the scoreboard = done.
    logic [31:0] mm;
    int          pend[$];
    int          sbq[$];
    int          ph;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (valid && ready) begin
                    if (sbq.size() == 0) chk("sb_unexpected_index", int'(A), -2);
                    else chk("sb_index", int'(A), sbq.pop_front());
                end
                if (done) begin
                    if (sbq.size() == 0) chk("sb_unexpected_done", -1, -2);
                    else chk("sb_done", -1, sbq.pop_front());
                end
            end
        end
    end

    task automatic check_outputs();
        chk("dirty_count", int'(dirty_count), $countones(mm));
        chk("busy", int'(busy), int'(ph != 0));
        chk("valid", int'(valid), int'(ph == 1));
        chk("done", int'(done), int'(ph == 2));
        chk("A", int'(A), (ph == 1) ? pend[0] : 0);
    endtask

    task automatic step(input logic [31:0] e, input logic s, input logic r);
        logic [31:0] em;
        en = e; start = s; ready = r;
        @(posedge clk);
        em = (C_IGNORE_X0 != 0) ? (e & 32'hFFFF_FFFE) : e;
        case (ph)
            0: begin
                if (s && mm != 0) begin
                    for (int i = 0; i < 32; i++) begin
                        if (mm[i]) begin
                            pend.push_back(i);
                            sbq.push_back(i);
                        end
                    end
                    sbq.push_back(-1);
                    mm = em;
                    ph = 1;
                end else if (s) begin
                    sbq.push_back(-1);
                    mm = mm | em;
                    ph = 2;
                end else begin
                    mm = mm | em;
                end
            end
            1: begin
                mm = mm | em;
                if (r) begin
                    void'(pend.pop_front());
                    if (pend.size() == 0) ph = 2;
                end
            end
            default: begin
                mm = mm | em;
                ph = 0;
            end
        endcase
        #1;
        check_outputs();
    endtask

    task automatic rst_step();
        reset = 1'b1; en = '0; start = 1'b0; ready = 1'b0;
        @(posedge clk);
        mm = '0; ph = 0; pend.delete(); sbq.delete();
        #1;
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        reset = 1'b1; en = '0; start = 1'b0; ready = 1'b0;
        mm = '0; ph = 0;
        rst_step();

        // Three single writes, then drain at full rate.
        step(32'h1 << 3, 0, 0);
        step(32'h1 << 1, 0, 0);
        step(32'h1 << 7, 0, 0);
        step(0, 1, 1);
        repeat (3) step(0, 0, 1);
        step(0, 0, 0);

        // Backpressure on {5, 9}.
        step((32'h1 << 5) | (32'h1 << 9), 0, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        repeat (2) step(0, 0, 1);
        step(0, 0, 0);

        // x0 writes are dropped; empty drain gives only a done pulse.
        step(32'h1, 0, 0);
        step(0, 1, 1);
        step(0, 0, 1);

        // Rewrite of reg 9 during its own drain.
        step(32'h1 << 5, 0, 0);
        step(32'h1 << 9, 0, 0);
        step(0, 1, 1);
        step(32'h1 << 9, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Full mask.
        step(32'hFFFF_FFFF, 0, 0);
        step(0, 1, 1);
        repeat (31) step(0, 0, 1);
        step(0, 0, 0);

        // Reset while the second index is presented.
        step((32'h1 << 2) | (32'h1 << 4) | (32'h1 << 6), 0, 0);
        step(0, 1, 1);
        step(0, 0, 1);
        rst_step();
        repeat (2) step(0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] e;
            e = '0;
            if ($urandom_range(0, 2) == 0) e = 32'h1 << $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) e = e | $urandom;
            step(e, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 100 && ph != 0; n++) step(0, 0, 1);
        step(0, 0, 0);
        chk("phase_idle", ph, 0);
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
